piano_poly_tone: RTL

//  Parametrised successor to the 4-switch square-wave piano tone generator.

---
 rtl/piano_poly_tone.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/piano_poly_tone.sv
// Polyphonic-input square-wave tone generator: NUM_KEYS synchronised and debounced keys,
// lowest-index pressed key sounds at its table half period, shifted down by the octave input.
module piano_poly_tone #(
  parameter int NUM_KEYS  = 8,
  parameter int IDX_W     = 3,
  parameter int TICK_DIV  = 2500,
  parameter int DEB_TICKS = 200,
  parameter int HP_W      = 10,
  parameter logic [NUM_KEYS*HP_W-1:0] HALF_TABLE =
    {10'd38, 10'd40, 10'd45, 10'd51, 10'd57, 10'd60, 10'd68, 10'd76}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEY_N,
  input  logic [1:0]          OCT,
  input  logic                MUTE,
  output logic                Speaker,
  output logic [NUM_KEYS-1:0] LED,
  output logic                NOTE_ON,
  output logic [IDX_W-1:0]    NOTE_IDX
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] stable;
  logic [DW-1:0]       deb_cnt [NUM_KEYS];
  logic [IDX_W-1:0]    win;
  logic [HP_W-1:0]     win_hp;
  logic [HP_W-1:0]     hp_shift;
  logic [HP_W-1:0]     hp_eff;
  logic                any_key;
  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [HP_W-1:0]     hp, hp_n;
  logic [HP_W-1:0]     phase, phase_n;
  logic                tone, tone_n;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Synchroniser resets to "released" so no phantom press is seen after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= KEY_N;
      key_sync <= key_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable <= '1;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt[k] <= '0;
    end else if (tick) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_sync[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          stable[k]  <= key_sync[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign LED = ~stable;

  // Descending scan so the lowest enabled pressed key wins; a zero table entry disables a key.
  always_comb begin
    win     = '0;
    win_hp  = '0;
    any_key = 1'b0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (LED[k] && (HALF_TABLE[k*HP_W +: HP_W] != '0)) begin
        win     = IDX_W'(k);
        win_hp  = HALF_TABLE[k*HP_W +: HP_W];
        any_key = 1'b1;
      end
    end
  end

  assign hp_shift = win_hp >> OCT;
  assign hp_eff   = (hp_shift == '0) ? HP_W'(1) : hp_shift;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hp_n    = hp;
    phase_n = phase;
    tone_n  = tone;
    if (tick) begin
      case (state)
        IDLE: begin
          tone_n = 1'b0;
          if (any_key) begin
            state_n = PLAY;
            idx_n   = win;
            hp_n    = hp_eff;
            phase_n = '0;
            tone_n  = 1'b1;
          end
        end
        PLAY: begin
          if (!any_key) begin
            state_n = IDLE;
            tone_n  = 1'b0;
          end else if ((win != idx) || (hp_eff != hp)) begin
            idx_n   = win;
            hp_n    = hp_eff;
            phase_n = '0;
            tone_n  = 1'b1;
          end else if (phase == hp - HP_W'(1)) begin
            phase_n = '0;
            tone_n  = ~tone;
          end else begin
            phase_n = phase + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      idx     <= '0;
      hp      <= '0;
      phase   <= '0;
      tone    <= 1'b0;
      Speaker <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      hp      <= hp_n;
      phase   <= phase_n;
      tone    <= tone_n;
      Speaker <= tone & ~MUTE;
    end
  end

  assign NOTE_ON  = (state == PLAY);
  assign NOTE_IDX = idx;

endmodule
